// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/IO responder: IO window decode and transmitter states.
package ram_io_responder_pkg;

    localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0] IO_STAT_ADDR = 18'h30004;

    localparam int          IO_SEL_HI    = 17;
    localparam int          IO_SEL_LO    = 16;
    localparam logic [1:0]  IO_SEL_VALUE = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide FIFO with a separate occupancy counter; a pop in the same cycle frees room for a push.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Responder for the byte-wide memory bus: RAM, an RX FIFO read window and a TX FIFO feeding an 8N1 transmitter.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 4,
    parameter int BAUD_DIV       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_ram_write_flag,
    input  logic [31:0] in_ram_address,
    input  logic [7:0]  in_ram_data,
    output logic [7:0]  out_ram_data,
    output logic        out_uart_full,
    output logic        out_tx,
    input  logic        in_rx_valid,
    input  logic [7:0]  in_rx_byte,
    output logic        out_rx_full,
    output logic        out_tx_overflow
);

    localparam int TX_CW  = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW  = $clog2(RX_DEPTH) + 1;
    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [13:0]               unused_addr_bits;
    logic [17:0]               bus_addr;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      sel_io;
    logic                      hit_data;
    logic                      hit_stat;
    logic                      ram_we;
    logic                      ram_re;

    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [7:0]                ram_rd_q;
    logic                      rd_from_ram_q;
    logic [7:0]                io_rd_q;
    logic [7:0]                io_rd_next;

    logic                      tx_push;
    logic                      tx_push_ok;
    logic                      tx_pop;
    logic [7:0]                tx_head;
    logic [TX_CW-1:0]          tx_count;
    logic [TX_CW-1:0]          tx_count_next;
    logic                      tx_full;
    logic                      tx_empty;

    logic                      rx_pop;
    logic                      rx_pop_ok;
    logic                      rx_push_ok;
    logic [7:0]                rx_head;
    logic [RX_CW-1:0]          rx_count;
    logic [RX_CW-1:0]          rx_count_next;
    logic                      rx_full;
    logic                      rx_empty;

    logic                      uart_full_q;
    logic                      rx_full_q;
    logic                      overflow_q;

    tx_state_e                 tx_state;
    tx_state_e                 tx_state_next;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [2:0]                bit_cnt;
    logic [7:0]                shift_q;
    logic                      baud_done;

    assign unused_addr_bits = in_ram_address[31:18];
    assign bus_addr         = in_ram_address[17:0];
    assign ram_addr         = in_ram_address[RAM_ADDR_WIDTH-1:0];
    assign sel_io           = (in_ram_address[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VALUE);
    assign hit_data         = (bus_addr == IO_DATA_ADDR);
    assign hit_stat         = (bus_addr == IO_STAT_ADDR);
    assign ram_we           = in_ram_write_flag && !sel_io;
    assign ram_re           = !in_ram_write_flag && !sel_io;

    assign tx_push          = in_ram_write_flag && hit_data;
    assign rx_pop           = !in_ram_write_flag && hit_data;

    // RAM array carries no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= in_ram_data;
        end
        ram_rd_q <= ram[ram_addr];
    end

    always_comb begin
        io_rd_next = 8'h00;
        if (!in_ram_write_flag) begin
            if (hit_data && !rx_empty) begin
                io_rd_next = rx_head;
            end else if (hit_stat) begin
                io_rd_next = {6'b0, !rx_empty, tx_full};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_from_ram_q <= 1'b0;
            io_rd_q       <= 8'h00;
        end else begin
            rd_from_ram_q <= ram_re;
            io_rd_q       <= io_rd_next;
        end
    end

    assign out_ram_data = rd_from_ram_q ? ram_rd_q : io_rd_q;

    byte_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (in_ram_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    byte_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_rx_valid),
        .push_data (in_rx_byte),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Post-update occupancies; the 2-entry headroom covers the controller's sampling delay.
    assign tx_push_ok    = tx_push && (!tx_full || tx_pop);
    assign tx_count_next = tx_count + TX_CW'(tx_push_ok) - TX_CW'(tx_pop);
    assign rx_pop_ok     = rx_pop && !rx_empty;
    assign rx_push_ok    = in_rx_valid && (!rx_full || rx_pop_ok);
    assign rx_count_next = rx_count + RX_CW'(rx_push_ok) - RX_CW'(rx_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_full_q <= 1'b0;
            rx_full_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            uart_full_q <= (tx_count_next >= TX_CW'(TX_DEPTH - 2));
            rx_full_q   <= (rx_count_next == RX_CW'(RX_DEPTH));
            if (tx_push && !tx_push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_uart_full   = uart_full_q;
    assign out_rx_full     = rx_full_q;
    assign out_tx_overflow = overflow_q;

    assign baud_done = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_state_next = TX_START;
            TX_START: if (baud_done) tx_state_next = TX_DATA;
            TX_DATA:  if (baud_done && bit_cnt == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (baud_done) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = 1'b0;
        out_tx = 1'b1;
        case (tx_state)
            TX_IDLE:  tx_pop = !tx_empty;
            TX_START: out_tx = 1'b0;
            TX_DATA:  out_tx = shift_q[0];
            default:  out_tx = 1'b1;
        endcase
    end

    // Baud and bit counters restart at every state boundary; data goes out LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
        end else begin
            if (tx_state == TX_IDLE || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (tx_pop) begin
                shift_q <= tx_head;
            end else if (tx_state == TX_DATA && baud_done) begin
                shift_q <= shift_q >> 1;
            end
            if (tx_state == TX_START) begin
                bit_cnt <= 3'd0;
            end else if (tx_state == TX_DATA && baud_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: a queue/array reference model predicts every cycle's outputs.
module tb_ram_io_responder;

    localparam int RAM_AW   = 17;
    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 4;
    localparam int BAUD     = 4;
    localparam int FRAME    = 10 * BAUD;
    localparam logic [31:0] IO_DATA = 32'h0003_0000;
    localparam logic [31:0] IO_STAT = 32'h0003_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_ram_write_flag = 1'b0;
    logic [31:0] in_ram_address = 32'h0;
    logic [7:0]  in_ram_data = 8'h00;
    logic [7:0]  out_ram_data;
    logic        out_uart_full;
    logic        out_tx;
    logic        in_rx_valid = 1'b0;
    logic [7:0]  in_rx_byte = 8'h00;
    logic        out_rx_full;
    logic        out_tx_overflow;

    typedef struct {
        logic [7:0] rdata;
        bit         check_rdata;
        bit         uart_full;
        bit         rx_full;
        bit         overflow;
        bit         tx;
    } expect_t;

    expect_t    sbq[$];
    expect_t    mon_e;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] ram_m [int];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         busy = 0;
    logic [7:0] frame_byte = 8'h00;
    bit         overflow_m = 1'b0;

    ram_io_responder #(
        .RAM_ADDR_WIDTH(RAM_AW),
        .TX_DEPTH      (TX_DEPTH),
        .RX_DEPTH      (RX_DEPTH),
        .BAUD_DIV      (BAUD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_ram_write_flag(in_ram_write_flag),
        .in_ram_address   (in_ram_address),
        .in_ram_data      (in_ram_data),
        .out_ram_data     (out_ram_data),
        .out_uart_full    (out_uart_full),
        .out_tx           (out_tx),
        .in_rx_valid      (in_rx_valid),
        .in_rx_byte       (in_rx_byte),
        .out_rx_full      (out_rx_full),
        .out_tx_overflow  (out_tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Line level during a frame, derived from the elapsed time since the byte was taken.
    function automatic bit serialLevel();
        int k;
        int idx;
        if (busy == 0) return 1'b1;
        k   = FRAME - busy;
        idx = k / BAUD;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return frame_byte[idx-1];
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [7:0] wdata,
                                 input logic rxv, input logic [7:0] rxb);
        expect_t     e;
        logic [17:0] a;
        bit          is_io;
        int          ram_key;
        @(negedge clk);
        in_ram_write_flag = we;
        in_ram_address    = addr;
        in_ram_data       = wdata;
        in_rx_valid       = rxv;
        in_rx_byte        = rxb;

        a       = addr[17:0];
        is_io   = (a >= 18'h30000);
        ram_key = int'(a[16:0]);
        e.rdata = 8'h00;
        e.check_rdata = 1'b1;
        if (!we) begin
            if (!is_io) begin
                if (ram_m.exists(ram_key)) e.rdata = ram_m[ram_key];
                else e.check_rdata = 1'b0;
            end else if (a == IO_DATA[17:0]) begin
                if (rxq.size() > 0) e.rdata = rxq[0];
            end else if (a == IO_STAT[17:0]) begin
                e.rdata = {6'b0, rxq.size() > 0, txq.size() == TX_DEPTH};
            end
        end

        if (busy == 0 && txq.size() > 0) begin
            frame_byte = txq.pop_front();
            busy = FRAME;
        end else if (busy > 0) begin
            busy--;
        end
        if (we && a == IO_DATA[17:0]) begin
            if (txq.size() < TX_DEPTH) txq.push_back(wdata);
            else overflow_m = 1'b1;
        end
        if (!we && a == IO_DATA[17:0] && rxq.size() > 0) void'(rxq.pop_front());
        if (rxv && rxq.size() < RX_DEPTH) rxq.push_back(rxb);
        if (we && !is_io) ram_m[ram_key] = wdata;

        e.uart_full = (txq.size() >= TX_DEPTH - 2);
        e.rx_full   = (rxq.size() == RX_DEPTH);
        e.overflow  = overflow_m;
        e.tx        = serialLevel();
        sbq.push_back(e);
    endtask

    // Monitor: one scoreboard entry per cycle, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            if (mon_e.check_rdata) checkOutput("rdata", 32'(out_ram_data), 32'(mon_e.rdata));
            checkOutput("uart_full", 32'(out_uart_full), 32'(mon_e.uart_full));
            checkOutput("rx_full", 32'(out_rx_full), 32'(mon_e.rx_full));
            checkOutput("tx_overflow", 32'(out_tx_overflow), 32'(mon_e.overflow));
            checkOutput("tx_line", 32'(out_tx), 32'(mon_e.tx));
        end
    end

    initial begin
        int          sel;
        logic [31:0] addr;
        logic [31:0] upper;
        logic        we;
        bit          found;

        #1 rst = 1'b1;
        #2;
        checkOutput("reset_rdata", 32'(out_ram_data), 32'h0);
        checkOutput("reset_uart_full", 32'(out_uart_full), 32'h0);
        checkOutput("reset_tx", 32'(out_tx), 32'h1);
        checkOutput("reset_rx_full", 32'(out_rx_full), 32'h0);
        checkOutput("reset_overflow", 32'(out_tx_overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] RAM write/read");
        applyStimulus(1'b1, 32'h10, 8'hA5, 1'b0, 8'h00);
        applyStimulus(1'b0, 32'h10, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h10 + 32'(i), 8'(8'h11 * (i + 1)), 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h10 + 32'(i), 8'h00, 1'b0, 8'h00);

        $display("[TB] RX FIFO reads");
        applyStimulus(1'b0, 32'h10, 8'h00, 1'b1, 8'h0D);
        applyStimulus(1'b0, 32'h10, 8'h00, 1'b1, 8'h0A);
        applyStimulus(1'b0, IO_STAT, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, IO_DATA, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, IO_DATA, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, IO_STAT, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, IO_DATA, 8'h00, 1'b0, 8'h00);

        $display("[TB] single TX frame");
        applyStimulus(1'b1, IO_DATA, 8'h41, 1'b0, 8'h00);
        repeat (45) applyStimulus(1'b0, 32'h11, 8'h00, 1'b0, 8'h00);

        $display("[TB] TX back-pressure");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, IO_DATA, 8'(8'h50 + i), 1'b0, 8'h00);

        $display("[TB] RX full with simultaneous push/pop");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h12, 8'h00, 1'b1, 8'(8'hC0 + i));
        applyStimulus(1'b0, IO_DATA, 8'h00, 1'b1, 8'hEE);
        applyStimulus(1'b0, IO_STAT, 8'h00, 1'b0, 8'h00);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            sel   = int'($urandom_range(0, 9));
            upper = $urandom & 32'hFFFC_0000;
            case (sel)
                0, 1, 2, 3: addr = upper | 32'($urandom_range(0, 63));
                4:          addr = upper | 32'h0001_0000 | 32'($urandom_range(0, 63));
                5, 6:       addr = upper | IO_DATA;
                7:          addr = upper | IO_STAT;
                8:          addr = upper | (IO_DATA + 32'h8 + 32'($urandom_range(0, 1000)));
                default:    addr = upper | 32'h0002_0000 | 32'($urandom_range(0, 63));
            endcase
            we = (sel == 5 || sel == 6) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 40);
            applyStimulus(we, addr, 8'($urandom), $urandom_range(0, 99) < 25, 8'($urandom));
        end

        $display("[TB] reset during a frame");
        applyStimulus(1'b1, IO_DATA, 8'h96, 1'b0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            applyStimulus(1'b0, 32'h10, 8'h00, 1'b0, 8'h00);
            if (busy >= FRAME - 19 && busy <= FRAME - 16) found = 1'b1;
        end
        checkOutput("reach_data_bit3", 32'(found), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midframe_rst_tx", 32'(out_tx), 32'h1);
        checkOutput("midframe_rst_uart_full", 32'(out_uart_full), 32'h0);
        checkOutput("midframe_rst_rdata", 32'(out_ram_data), 32'h0);
        checkOutput("midframe_rst_overflow", 32'(out_tx_overflow), 32'h0);
        txq.delete();
        rxq.delete();
        busy = 0;
        overflow_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) applyStimulus(1'b0, 32'h10, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the byte-wide memory bus driven by the memory controller.
- Services 1-byte reads and writes to a byte-addressed RAM, and to a memory-mapped IO window.
- IO writes go into a TX FIFO that feeds an 8N1 serial transmitter. IO reads pop bytes from an RX FIFO.
- Generates the uart-full back-pressure signal that the controller samples before writing to IO.

Parameters:
- RAM_ADDR_WIDTH, 17: RAM depth is 2^RAM_ADDR_WIDTH bytes.
- TX_DEPTH, 8: TX FIFO entries (power of 2, >=4).
- RX_DEPTH, 4: RX FIFO entries (power of 2, >=2).
- BAUD_DIV, 4: clk cycles per serial bit (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- in_ram_write_flag  in  1  write strobe for the current byte.
- in_ram_address  in  32  byte address.
- in_ram_data  in  8  write data.
- out_ram_data  out  8  read data. Registered; valid 1 cycle after the address is presented.
- out_uart_full  out  1  TX back-pressure.
- out_tx  out  1  serial transmit line; idles high.
- in_rx_valid  in  1  push in_rx_byte into the RX FIFO.
- in_rx_byte  in  8  received byte.
- out_rx_full  out  1  RX FIFO full; a push while full is dropped.
- out_tx_overflow  out  1  sticky: an IO write occurred while the TX FIFO was full.

Behaviour:
- Reset values (async, immediate):
  - out_ram_data=0, out_uart_full=0, out_tx=1, out_rx_full=0, out_tx_overflow=0.
  - FIFO pointers and counts = 0; transmitter in IDLE.
  - RAM contents are not reset.
- Address decode:
  - in_ram_address[17:16]==2'b11 selects IO. Otherwise RAM at in_ram_address[RAM_ADDR_WIDTH-1:0].
  - Address bits above 17 are ignored.
  - IO_DATA = 0x30000. IO_STAT = 0x30004. Other IO addresses: reads return 0, writes are ignored.
- Every cycle, exactly one access is performed:
  - Write when in_ram_write_flag=1, otherwise read. There is no idle indication.
- RAM write: byte stored at the clk edge. out_ram_data for that cycle is don't-care; drive 0.
- RAM read: out_ram_data <= ram[addr] at the next edge, giving 1-cycle latency. A back-to-back address stream is supported.
- IO_DATA write:
  - TX FIFO not full: push in_ram_data.
  - TX FIFO full: drop the byte and set out_tx_overflow (cleared only by rst).
- IO_DATA read:
  - RX FIFO non-empty: out_ram_data <= head byte and pop.
  - RX FIFO empty: out_ram_data <= 0, no pop.
  - Reads with write_flag=0 at IO_DATA always pop. The controller issues exactly one IO read per load.
- IO_STAT read: out_ram_data <= {6'b0, rx_nonempty, tx_full}. No side effects.
- out_uart_full:
  - Registered: 1 when TX count (after this cycle's push/pop) >= TX_DEPTH-2.
  - The 2-entry headroom absorbs the controller's 2-cycle sampling delay.
- Simultaneous TX push and pop: count unchanged, both take effect. Same rule for RX push and IO_DATA pop.
- RX push when full: dropped, except that a simultaneous pop makes room and the push succeeds.
- out_rx_full is registered from the post-update count.
- Transmitter FSM, with a bit counter and a baud counter (0..BAUD_DIV-1):
  - IDLE: out_tx=1. If the TX FIFO is non-empty, pop into shift reg and go to START (pop occurs this cycle).
  - START: out_tx=0 for BAUD_DIV cycles, then go to DATA with bit=0.
  - DATA: out_tx=shift[0] for BAUD_DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: out_tx=1 for BAUD_DIV cycles, then IDLE. IDLE may pop again in the very next cycle, so frames are back-to-back with no extra idle bit.
- Pointer wrap: modulo depth via natural pointer overflow; count is kept separately, one bit wider than the pointer.
- Reset mid-frame: out_tx returns high immediately; the partial frame is lost.

Decomposition:
- Shared package: IO_DATA and IO_STAT addresses, IO-select bit positions, TX FSM state encoding.
- Sub-module byte_fifo:
  - Parameters: DEPTH.
  - Ports: push, push_data, pop, pop_data, count, full, empty. Push/pop semantics as above.
  - Instantiated twice, for TX and RX.
- Transmitter FSM and decode stay in the top module.

Test Plan:
- RAM: write 0xA5 to 0x00010, then read 0x00010 → out_ram_data=0xA5 exactly one cycle after the read address. Back-to-back reads of 0x00010..0x00013 after writing 11,22,33,44 → 11,22,33,44 on consecutive cycles.
- TX serial: BAUD_DIV=4, write 0x41 to 0x30000 → out_tx goes low within 2 cycles.
  - Then 4-cycle bits 1,0,0,0,0,0,1,0, followed by 4 high cycles.
  - Total frame is 40 cycles.
- Back-pressure: TX_DEPTH=8, 7 back-to-back IO writes while the transmitter is busy → out_uart_full=1 once count reaches 6.
  - The 9th write (FIFO full) is dropped and sets out_tx_overflow=1.
- RX: push 0x0D then 0x0A via in_rx_valid.
  - Read 0x30004 → 0x02.
  - Read 0x30000 twice → 0x0D, 0x0A.
  - Read 0x30004 → 0x00.
  - A 3rd read of 0x30000 → 0x00.
- Reset mid-frame: assert rst during DATA bit 3 → out_tx=1, out_uart_full=0 asynchronously. After release with no writes, out_tx stays 1 for 50 cycles.
- Simultaneous events: with the RX FIFO full, push and IO_DATA read in the same cycle → head byte returned, new byte accepted, out_rx_full stays 1.
